// File: rtl/tdm_demux.sv
// TDM receive-side demultiplexer: serial slots -> parallel channels, one publish per frame.
// Optional saturating error counter port err_cnt when TDM_DEMUX_ERRCNT_EN is defined.
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  localparam int SW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [W-1:0]      din,
  input  logic              sof,
  output logic [N_CH*W-1:0] dout,
  output logic              dout_valid,
  output logic              frame_err,
  output logic [SW-1:0]     slot
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [W-1:0]        shadow [N_CH];
  logic [N_CH*W-1:0]   frame_word;

  logic in_run;
  logic at_zero;
  logic start;
  logic resync;
  logic drop_err;
  logic store;
  logic last;

  assign in_run   = (state == RUN);
  assign at_zero  = (slot == '0);
  assign start    = din_valid & sof & (!in_run | at_zero);
  assign resync   = din_valid & sof & in_run & !at_zero;
  assign drop_err = din_valid & !sof & in_run & at_zero;
  assign store    = din_valid & !sof & in_run & !at_zero;
  assign last     = store & (slot == SW'(N_CH - 1));

  // Completed frame: stored slots plus the sample arriving this beat in the top slot.
  always_comb begin
    frame_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (k == N_CH - 1)
        frame_word[k*W +: W] = din;
      else
        frame_word[k*W +: W] = shadow[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      slot       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      for (int k = 0; k < N_CH; k++)
        shadow[k] <= '0;
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (start || resync) begin
        shadow[0] <= din;
        frame_err <= resync;
        state     <= RUN;
        if (N_CH == 1) begin
          dout       <= frame_word;
          dout_valid <= 1'b1;
          slot       <= '0;
        end else begin
          slot <= SW'(1);
        end
      end
      if (drop_err) begin
        frame_err <= 1'b1;
        state     <= IDLE;
        slot      <= '0;
      end
      if (store) begin
        shadow[slot] <= din;
        if (last) begin
          dout       <= frame_word;
          dout_valid <= 1'b1;
          slot       <= '0;
        end else begin
          slot <= slot + SW'(1);
        end
      end
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if ((resync || drop_err) && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (N_CH=4, W=8).
// Covers framing, gaps, resync, drop, async reset and the optional error counter.
module tb_tdm_demux;
  localparam int N_CH = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              din_valid = 1'b0;
  logic [W-1:0]      din = '0;
  logic              sof = 1'b0;
  logic [N_CH*W-1:0] dout;
  logic              dout_valid;
  logic              frame_err;
  logic [1:0]        slot;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0]        err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .sof        (sof),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_err  (frame_err),
    .slot       (slot)
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [W-1:0] d);
    @(negedge clk);
    din_valid = v;
    sof       = s;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int first_at;
    int second_at;
    int errs_seen;
    int dv_seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_dv", dout_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_slot", slot, 0);
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("rst_errcnt", err_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // 1: basic frame
    step(1, 1, 8'hA0);
    chk("t1_slot1", slot, 1);
    chk("t1_dv_early", dout_valid, 0);
    step(1, 0, 8'hA1);
    step(1, 0, 8'hA2);
    chk("t1_slot3", slot, 3);
    chk("t1_dv_pre", dout_valid, 0);
    step(1, 0, 8'hA3);
    chk("t1_dout", dout, 32'hA3A2A1A0);
    chk("t1_dv", dout_valid, 1);
    chk("t1_slot_wrap", slot, 0);
    step(0, 0, 8'h00);
    chk("t1_dv_pulse", dout_valid, 0);
    chk("t1_dout_hold", dout, 32'hA3A2A1A0);

    // 2: back-to-back frames
    pulses = 0;
    first_at = -1;
    second_at = -1;
    for (int i = 0; i < 8; i++) begin
      step(1, (i % 4) == 0, (i < 4) ? 8'hC0 + 8'(i) : 8'hD0 + 8'(i - 4));
      if (dout_valid) begin
        pulses++;
        if (first_at < 0) first_at = i;
        else second_at = i;
      end
      if (i == 3) chk("t2_dout_c", dout, 32'hC3C2C1C0);
    end
    chk("t2_pulses", pulses, 2);
    chk("t2_spacing", second_at - first_at, 4);
    chk("t2_dout_d", dout, 32'hD3D2D1D0);

    // 3: gaps between valid beats
    errs_seen = 0;
    dv_seen = 0;
    step(0, 1, 8'hEE);
    errs_seen += int'(frame_err); dv_seen += int'(dout_valid);
    step(1, 1, 8'hA0);
    errs_seen += int'(frame_err); dv_seen += int'(dout_valid);
    step(0, 0, 8'hEE);
    errs_seen += int'(frame_err); dv_seen += int'(dout_valid);
    step(0, 1, 8'hEE);
    errs_seen += int'(frame_err); dv_seen += int'(dout_valid);
    step(1, 0, 8'hA1);
    errs_seen += int'(frame_err); dv_seen += int'(dout_valid);
    step(0, 0, 8'hEE);
    errs_seen += int'(frame_err); dv_seen += int'(dout_valid);
    step(1, 0, 8'hA2);
    errs_seen += int'(frame_err); dv_seen += int'(dout_valid);
    step(0, 0, 8'hEE);
    errs_seen += int'(frame_err); dv_seen += int'(dout_valid);
    chk("t3_no_early_dv", dv_seen, 0);
    chk("t3_dout_held", dout, 32'hD3D2D1D0);
    step(1, 0, 8'hA3);
    errs_seen += int'(frame_err);
    chk("t3_dv", dout_valid, 1);
    chk("t3_dout", dout, 32'hA3A2A1A0);
    chk("t3_no_err", errs_seen, 0);

    // 4: early sof at slot 2 resyncs
    step(1, 1, 8'h10);
    step(1, 0, 8'h11);
    chk("t4_slot2", slot, 2);
    step(1, 1, 8'hF0);
    chk("t4_ferr", frame_err, 1);
    chk("t4_dv_low", dout_valid, 0);
    chk("t4_slot_resync", slot, 1);
    chk("t4_dout_kept", dout, 32'hA3A2A1A0);
    step(1, 0, 8'hF1);
    chk("t4_ferr_pulse", frame_err, 0);
    step(1, 0, 8'hF2);
    step(1, 0, 8'hF3);
    chk("t4_dv", dout_valid, 1);
    chk("t4_ferr_excl", frame_err, 0);
    chk("t4_dout", dout, 32'hF3F2F1F0);

    // 5: missing sof after a frame, then idle beats without sof
    step(1, 0, 8'h55);
    chk("t5_ferr", frame_err, 1);
    chk("t5_slot", slot, 0);
    chk("t5_dv", dout_valid, 0);
    errs_seen = 0;
    dv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 8'h60 + 8'(i));
      errs_seen += int'(frame_err);
      dv_seen += int'(dout_valid);
    end
    chk("t5_idle_ferr", errs_seen, 0);
    chk("t5_idle_dv", dv_seen, 0);
    chk("t5_idle_slot", slot, 0);
    chk("t5_idle_dout", dout, 32'hF3F2F1F0);

    // 6: asynchronous reset mid-frame
    step(1, 1, 8'h70);
    step(1, 0, 8'h71);
    chk("t6_slot2", slot, 2);
    @(negedge clk);
    din_valid = 1'b0;
    sof = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("t6_async_dout", dout, 0);
    chk("t6_async_slot", slot, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 8'h72);
    chk("t6_idle_after_rst", frame_err, 0);

`ifdef TDM_DEMUX_ERRCNT_EN
    chk("t6_errcnt_clr", err_cnt, 0);
    step(1, 1, 8'h80);
    for (int i = 0; i < 300; i++)
      step(1, 1, 8'h81);
    chk("t6_errcnt_sat", err_cnt, 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
